// File: rtl/char_layer_mux.sv
// -----------------------------------------------------------------------------
// char_layer_mux
//
// Pipelined pixel compositor placed between the character ROM pixel generators
// and the HDMI encoder. Each clock it takes one pixel from NUM_LAYERS RGB
// sources and picks the lit layer with the lowest index. Where no layer is lit
// it uses the background colour, and it forces black outside the active
// display area. Layers may blink. The blink phase flips every BLINK_FRAMES
// vsync rising edges. The video timing is delayed by the same number of clocks
// as the colour so the two stay aligned.
//
// Ports:
//   clk                         pixel clock, rising edge
//   reset                       asynchronous, active-high
//   layer_en[NUM_LAYERS]        per-layer "pixel lit" flag for this pixel
//   layer_blink[NUM_LAYERS]     per-layer blink enable
//   layer_red/green/blue        flattened layer colours, layer i at
//                               [i*CH_WIDTH +: CH_WIDTH]
//   bg_red/green/blue           background colour
//   de_in/hsync_in/vsync_in     timing aligned with the layer inputs
//   red/green/blue              composited pixel, PIPE_DEPTH clocks later
//   de_out/hsync_out/vsync_out  timing, PIPE_DEPTH clocks later
//   blink_phase                 1 = blinking layers currently hidden
//
// Data flow: each clock one pixel enters and the pixel from PIPE_DEPTH clocks
// earlier leaves. Nothing stalls, and there is no flow control.
// -----------------------------------------------------------------------------
module char_layer_mux #(
  parameter int CH_WIDTH     = 8,
  parameter int NUM_LAYERS   = 4,
  parameter int PIPE_DEPTH   = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LAYERS-1:0]          layer_en,
  input  logic [NUM_LAYERS-1:0]          layer_blink,
  input  logic [NUM_LAYERS*CH_WIDTH-1:0] layer_red,
  input  logic [NUM_LAYERS*CH_WIDTH-1:0] layer_green,
  input  logic [NUM_LAYERS*CH_WIDTH-1:0] layer_blue,
  input  logic [CH_WIDTH-1:0]            bg_red,
  input  logic [CH_WIDTH-1:0]            bg_green,
  input  logic [CH_WIDTH-1:0]            bg_blue,
  input  logic                           de_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  output logic [CH_WIDTH-1:0]            red,
  output logic [CH_WIDTH-1:0]            green,
  output logic [CH_WIDTH-1:0]            blue,
  output logic                           de_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           blink_phase
);

  localparam int                CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Blink counter
  // ---------------------------------------------------------------------------
  logic             vsync_q;
  logic             edge_ok;     // low for the first clock after reset
  logic [CNT_W-1:0] frame_cnt;
  logic             vsync_rise;

  // vsync_q restarts at 0 after reset. If vsync_in is already high on that
  // first clock, it would look like a rising edge. edge_ok masks that clock.
  assign vsync_rise = edge_ok & vsync_in & ~vsync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      edge_ok     <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      edge_ok <= 1'b1;
      if (vsync_rise) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Layer selection
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] eff;
  logic [CH_WIDTH-1:0]   mix_r;
  logic [CH_WIDTH-1:0]   mix_g;
  logic [CH_WIDTH-1:0]   mix_b;

  // A blinking layer is hidden only during the hidden phase, so a lower
  // priority layer or the background shows through in its place.
  assign eff = layer_en & ~(layer_blink & {NUM_LAYERS{blink_phase}});

  // The loop runs from the lowest priority to the highest. Each later match
  // overwrites the earlier one, so the lowest set index wins.
  always_comb begin
    mix_r = bg_red;
    mix_g = bg_green;
    mix_b = bg_blue;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        mix_r = layer_red[i*CH_WIDTH +: CH_WIDTH];
        mix_g = layer_green[i*CH_WIDTH +: CH_WIDTH];
        mix_b = layer_blue[i*CH_WIDTH +: CH_WIDTH];
      end
    end
    if (!de_in) begin
      mix_r = '0;
      mix_g = '0;
      mix_b = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline: stage 0 registers the mix, later stages only delay it. Timing
  // signals run through a shift register of the same depth.
  // ---------------------------------------------------------------------------
  logic [CH_WIDTH-1:0]   r_pipe [PIPE_DEPTH];
  logic [CH_WIDTH-1:0]   g_pipe [PIPE_DEPTH];
  logic [CH_WIDTH-1:0]   b_pipe [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] de_pipe;
  logic [PIPE_DEPTH-1:0] hs_pipe;
  logic [PIPE_DEPTH-1:0] vs_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        r_pipe[s] <= '0;
        g_pipe[s] <= '0;
        b_pipe[s] <= '0;
      end
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      r_pipe[0]  <= mix_r;
      g_pipe[0]  <= mix_g;
      b_pipe[0]  <= mix_b;
      de_pipe[0] <= de_in;
      hs_pipe[0] <= hsync_in;
      vs_pipe[0] <= vsync_in;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        r_pipe[s]  <= r_pipe[s-1];
        g_pipe[s]  <= g_pipe[s-1];
        b_pipe[s]  <= b_pipe[s-1];
        de_pipe[s] <= de_pipe[s-1];
        hs_pipe[s] <= hs_pipe[s-1];
        vs_pipe[s] <= vs_pipe[s-1];
      end
    end
  end

  assign red       = r_pipe[PIPE_DEPTH-1];
  assign green     = g_pipe[PIPE_DEPTH-1];
  assign blue      = b_pipe[PIPE_DEPTH-1];
  assign de_out    = de_pipe[PIPE_DEPTH-1];
  assign hsync_out = hs_pipe[PIPE_DEPTH-1];
  assign vsync_out = vs_pipe[PIPE_DEPTH-1];

endmodule

// File: tb/tb_char_layer_mux.sv
// -----------------------------------------------------------------------------
// tb_char_layer_mux
//
// Three compositors with depths 2, 1 and 4 (BLINK_FRAMES=2) share one input
// stream. Each directed pixel pushes its hand-computed output, tagged with the
// cycle it must appear, into a queue per instance. A negedge monitor pops the
// queues and compares.
// -----------------------------------------------------------------------------
module tb_char_layer_mux;

  localparam int CW    = 8;
  localparam int NL    = 4;
  localparam int EXP_W = 16 + 24 + 3;   // {due, rgb, de, hs, vs}

  localparam logic [23:0] L0 = 24'hF0E0D0;
  localparam logic [23:0] L1 = 24'h112233;
  localparam logic [23:0] L2 = 24'hAABBCC;
  localparam logic [23:0] L3 = 24'h445566;
  localparam logic [23:0] BG = 24'h050607;
  localparam logic [23:0] BLK = 24'h000000;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT signals
  logic [NL-1:0]    layer_en;
  logic [NL-1:0]    layer_blink;
  logic [NL*CW-1:0] layer_red, layer_green, layer_blue;
  logic [CW-1:0]    bg_red, bg_green, bg_blue;
  logic             de_in, hsync_in, vsync_in;

  logic [CW-1:0] red2, green2, blue2, red1, green1, blue1, red4, green4, blue4;
  logic de2, hs2, vs2, de1, hs1, vs1, de4, hs4, vs4;
  logic ph2, ph1, ph4;

  char_layer_mux #(.CH_WIDTH(CW), .NUM_LAYERS(NL), .PIPE_DEPTH(2), .BLINK_FRAMES(2)) u_d2 (
    .clk(clk), .reset(rst), .layer_en(layer_en), .layer_blink(layer_blink),
    .layer_red(layer_red), .layer_green(layer_green), .layer_blue(layer_blue),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red2), .green(green2), .blue(blue2),
    .de_out(de2), .hsync_out(hs2), .vsync_out(vs2), .blink_phase(ph2));

  char_layer_mux #(.CH_WIDTH(CW), .NUM_LAYERS(NL), .PIPE_DEPTH(1), .BLINK_FRAMES(2)) u_d1 (
    .clk(clk), .reset(rst), .layer_en(layer_en), .layer_blink(layer_blink),
    .layer_red(layer_red), .layer_green(layer_green), .layer_blue(layer_blue),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red1), .green(green1), .blue(blue1),
    .de_out(de1), .hsync_out(hs1), .vsync_out(vs1), .blink_phase(ph1));

  char_layer_mux #(.CH_WIDTH(CW), .NUM_LAYERS(NL), .PIPE_DEPTH(4), .BLINK_FRAMES(2)) u_d4 (
    .clk(clk), .reset(rst), .layer_en(layer_en), .layer_blink(layer_blink),
    .layer_red(layer_red), .layer_green(layer_green), .layer_blue(layer_blue),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red4), .green(green4), .blue(blue4),
    .de_out(de4), .hsync_out(hs4), .vsync_out(vs4), .blink_phase(ph4));

  // ---------------------------------------------------------------- scoreboard
  logic [EXP_W-1:0] exp_q2[$];
  logic [EXP_W-1:0] exp_q1[$];
  logic [EXP_W-1:0] exp_q4[$];
  int n_cmp;
  int n_fail;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  logic [EXP_W-1:0] ent2, ent1, ent4;

  always @(negedge clk) begin
    if (exp_q2.size() > 0 && exp_q2[0][EXP_W-1 -: 16] <= cyc[15:0]) begin
      ent2 = exp_q2.pop_front();
      check("d2_pix", {5'd0, red2, green2, blue2, de2, hs2, vs2}, {5'd0, ent2[26:0]});
    end
    if (exp_q1.size() > 0 && exp_q1[0][EXP_W-1 -: 16] <= cyc[15:0]) begin
      ent1 = exp_q1.pop_front();
      check("d1_pix", {5'd0, red1, green1, blue1, de1, hs1, vs1}, {5'd0, ent1[26:0]});
    end
    if (exp_q4.size() > 0 && exp_q4[0][EXP_W-1 -: 16] <= cyc[15:0]) begin
      ent4 = exp_q4.pop_front();
      check("d4_pix", {5'd0, red4, green4, blue4, de4, hs4, vs4}, {5'd0, ent4[26:0]});
    end
  end

  // ---------------------------------------------------------------- drivers
  // Drives one pixel, which is sampled on the next rising edge, and queues
  // its expected output for each depth.
  task automatic pix(input logic [3:0] en, input logic de, input logic hs,
                     input logic vs, input logic [23:0] exp);
    layer_en = en;
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    exp_q2.push_back({16'(cyc + 2), exp, de, hs, vs});
    exp_q1.push_back({16'(cyc + 1), exp, de, hs, vs});
    exp_q4.push_back({16'(cyc + 4), exp, de, hs, vs});
    @(posedge clk);
    #1;
  endtask

  // One frame's worth of pixels: the first one carries the vsync rise.
  task automatic frame(input logic [3:0] en, input logic [23:0] first,
                       input logic [23:0] rest, input logic exp_phase,
                       input int exp_cnt);
    pix(en, 1'b1, 1'b0, 1'b1, first);
    repeat (3) pix(en, 1'b1, 1'b0, 1'b0, rest);
    check("phase_d2", {31'd0, ph2}, {31'd0, exp_phase});
    check("phase_d4", {31'd0, ph4}, {31'd0, exp_phase});
    check("frame_cnt", 32'(u_d2.frame_cnt), 32'(exp_cnt));
  endtask

  // Asserts reset between edges, checks that the outputs clear at once and
  // stay clear while reset is held, then releases reset just after an edge.
  task automatic apply_reset(input logic vs_hold);
    #2;
    vsync_in = vs_hold;
    rst = 1'b1;
    exp_q2.delete();
    exp_q1.delete();
    exp_q4.delete();
    #1;
    check("rst_d2_out", {5'd0, red2, green2, blue2, de2, hs2, vs2}, 32'd0);
    check("rst_d1_out", {5'd0, red1, green1, blue1, de1, hs1, vs1}, 32'd0);
    check("rst_d4_out", {5'd0, red4, green4, blue4, de4, hs4, vs4}, 32'd0);
    check("rst_phase", {29'd0, ph1, ph2, ph4}, 32'd0);
    check("rst_frame_cnt", 32'(u_d2.frame_cnt), 32'd0);
    check("rst_vsync_q", {31'd0, u_d2.vsync_q}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_d2", {5'd0, red2, green2, blue2, de2, hs2, vs2}, 32'd0);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst         = 1'b0;
    layer_en    = 4'b0110;
    layer_blink = 4'b0000;
    layer_red   = {8'h44, 8'hAA, 8'h11, 8'hF0};
    layer_green = {8'h55, 8'hBB, 8'h22, 8'hE0};
    layer_blue  = {8'h66, 8'hCC, 8'h33, 8'hD0};
    bg_red      = 8'h05;
    bg_green    = 8'h06;
    bg_blue     = 8'h07;
    de_in       = 1'b1;
    hsync_in    = 1'b0;
    vsync_in    = 1'b1;
    #1;

    // vsync held high across reset release must not count as an edge.
    apply_reset(1'b1);
    repeat (4) pix(4'b0110, 1'b1, 1'b0, 1'b1, L1);
    check("vs_hold_cnt", 32'(u_d2.frame_cnt), 32'd0);
    check("vs_hold_phase", {31'd0, ph2}, 32'd0);

    // Background when nothing is lit.
    repeat (2) pix(4'b0000, 1'b1, 1'b0, 1'b1, BG);

    // First real low->high edge.
    pix(4'b0110, 1'b1, 1'b0, 1'b0, L1);
    pix(4'b0110, 1'b1, 1'b0, 1'b1, L1);
    check("first_edge_cnt", 32'(u_d2.frame_cnt), 32'd1);
    check("first_edge_phase", {31'd0, ph2}, 32'd0);

    // Blanking overrides every layer. hsync/vsync pass through unchanged.
    pix(4'b1111, 1'b0, 1'b1, 1'b1, BLK);
    pix(4'b1111, 1'b0, 1'b1, 1'b1, BLK);
    pix(4'b1111, 1'b0, 1'b0, 1'b1, BLK);
    pix(4'b1111, 1'b1, 1'b0, 1'b1, L0);
    pix(4'b1111, 1'b1, 1'b1, 1'b1, L0);
    pix(4'b1111, 1'b0, 1'b0, 1'b0, BLK);

    // Blink: layer 0 blinks over layer 1, with the phase flipping every 2nd edge.
    layer_blink = 4'b0001;
    apply_reset(1'b0);
    repeat (2) pix(4'b0011, 1'b1, 1'b0, 1'b0, L0);
    frame(4'b0011, L0, L0, 1'b0, 1);
    frame(4'b0011, L0, L1, 1'b1, 0);
    frame(4'b0011, L1, L1, 1'b1, 1);
    frame(4'b0011, L1, L0, 1'b0, 0);
    frame(4'b0011, L0, L0, 1'b0, 1);
    frame(4'b0011, L0, L1, 1'b1, 0);

    // Mid-line reset with phase=1 and a full pipeline.
    apply_reset(1'b0);

    // Mixed stream, checked at depths 1, 2 and 4.
    pix(4'b0011, 1'b1, 1'b0, 1'b0, L0);
    pix(4'b1000, 1'b1, 1'b1, 1'b0, L3);
    pix(4'b0100, 1'b1, 1'b1, 1'b0, L2);
    pix(4'b1010, 1'b1, 1'b0, 1'b0, L1);
    pix(4'b0000, 1'b1, 1'b0, 1'b0, BG);
    pix(4'b1111, 1'b0, 1'b0, 1'b0, BLK);
    pix(4'b0110, 1'b1, 1'b0, 1'b1, L1);
    pix(4'b0001, 1'b1, 1'b1, 1'b1, L0);
    pix(4'b0101, 1'b1, 1'b0, 1'b0, L0);
    pix(4'b1100, 1'b0, 1'b1, 1'b0, BLK);

    // Let the deepest pipeline drain, then every expectation must be consumed.
    repeat (6) @(posedge clk);
    #1;
    check("queues_drained", 32'(exp_q1.size() + exp_q2.size() + exp_q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/char_layer_mux.md
# char_layer_mux

Parametrised, pipelined pixel compositor sitting between the character ROM pixel generators and the HDMI encoder. It selects one of NUM_LAYERS RGB sources per pixel by fixed priority. Layers can be made to blink at a frame-counted rate. A background colour is substituted where no layer is active. The video timing signals (de/hsync/vsync) are delayed by the same pipeline depth so colour and sync stay aligned.

## Interface
Parameters:
- CH_WIDTH, 8, bits per colour channel
- NUM_LAYERS, 4, number of layer inputs; index 0 has highest priority; range 1..8
- PIPE_DEPTH, 2, pixel latency in clocks; range 1..4
- BLINK_FRAMES, 30, vsync rising edges per blink half-period; must be ≥1

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- layer_en  in  NUM_LAYERS  per-layer "pixel lit" flag for the current pixel (the old single sel, generalised)
- layer_blink  in  NUM_LAYERS  per-layer blink enable; static or quasi-static
- layer_red / layer_green / layer_blue  in  NUM_LAYERS*CH_WIDTH each  flattened layer colours; layer i at bits [i*CH_WIDTH +: CH_WIDTH]
- bg_red / bg_green / bg_blue  in  CH_WIDTH each  background colour
- de_in, hsync_in, vsync_in  in  1 each  video timing aligned with the layer inputs; vsync active-high
- red / green / blue  out  CH_WIDTH each  composited pixel
- de_out, hsync_out, vsync_out  out  1 each  timing delayed by PIPE_DEPTH
- blink_phase  out  1  current blink phase; 1 = blinking layers hidden

## Operation
- Effective enable per layer: eff[i] = layer_en[i] & ~(layer_blink[i] & blink_phase).
- Stage 1 (registered): winner = lowest i with eff[i]=1. Output colour = that layer's RGB. If no eff bit is set, output colour = bg RGB. If de_in=0, output colour = 0 regardless of layers or background.
- Stages 2..PIPE_DEPTH: pure delay registers for RGB and timing.
- Timing signals pass through a PIPE_DEPTH-stage shift register. They are not modified.
- Blink counter:
  - vsync_in is registered once. A rising edge is detected as vsync_in & ~vsync_q.
  - frame_cnt, width clog2(BLINK_FRAMES+1), increments on each detected edge.
  - When an edge arrives with frame_cnt = BLINK_FRAMES-1, frame_cnt wraps to 0 and blink_phase toggles.
  - With BLINK_FRAMES=1, blink_phase toggles on every edge.
- blink_phase changes only on a vsync edge, so blinking never changes mid-frame.
- Compositing sees the new blink_phase from the cycle after the toggle.

## Timing
- Latency: a pixel presented at cycle N appears on red/green/blue/de_out/hsync_out/vsync_out at cycle N+PIPE_DEPTH.
- Throughput: one pixel per clock, no stalls, no handshake.
- Reset (asynchronous assert): all of the following clear immediately, and pipeline contents are discarded:
  - red/green/blue = 0
  - de_out = hsync_out = vsync_out = 0
  - blink_phase = 0
  - frame_cnt = 0
  - vsync_q = 0
- First valid output after reset deassertion: PIPE_DEPTH clocks after the first sampled input.
- vsync_in held high through reset deassertion does not count as an edge, because vsync_q starts at 0 and the first sample sets it. Implementation must not count it: gate edge detection for one cycle after reset (a valid flag, reset to 0).
- Simultaneous events:
  - Several eff bits set → lowest index wins.
  - A blinking layer hidden by phase → the next lower-priority active layer or the background shows through.
- Reset mid-frame: outputs blank at once; compositing resumes with blink_phase=0.

## Test plan
- NUM_LAYERS=4, PIPE_DEPTH=2, de_in=1, layer_en=4'b0110:
  - layer1 = (0x11,0x22,0x33), layer2 = (0xAA,0xBB,0xCC) → outputs (0x11,0x22,0x33) exactly 2 clocks later.
  - Then layer_en=0, bg=(0x05,0x06,0x07) → bg 2 clocks later.
- de_in=0 with layer_en=4'b1111 → RGB 0 and de_out=0 at N+2. hsync/vsync pulses reproduced bit-exact with a 2-cycle delay.
- BLINK_FRAMES=2, layer_blink=4'b0001, layer_en=4'b0011:
  - Output shows layer0 for vsync edges 0–1.
  - blink_phase rises on the 2nd edge → layer1 colour shown.
  - 4th edge → back to layer0.
  - No change occurs between edges.
- vsync_in high during reset release, then steady → frame_cnt stays 0 and no toggle. First real low→high edge → frame_cnt=1.
- Assert reset mid-line with blink_phase=1 and pipeline full → all outputs 0 in the same cycle, blink_phase=0. After release, output is valid at PIPE_DEPTH latency.
- Sweep PIPE_DEPTH=1 and 4 with a random pixel stream checked against a reference model: latency matches and colour–timing alignment holds every cycle.
